// File: rtl/axi_ar_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_ar_rr_arbiter_if
// Shared AXI read-address (AR) and read-data (R) handshake bundle between the
// round-robin AR arbiter and the downstream interconnect. M_ID_W is the
// master-side ID width (requester ID plus requester-index prefix).
// ---------------------------------------------------------------------------
interface axi_ar_rr_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int M_ID_W = 6
);
  logic              m_ar_valid;
  logic              m_ar_ready;
  logic [ADDR_W-1:0] m_ar_addr;
  logic [M_ID_W-1:0] m_ar_id;
  logic              m_r_valid;
  logic              m_r_ready;
  logic              m_r_last;
  logic [M_ID_W-1:0] m_r_id;

  // Arbiter side: issues AR, accepts R
  modport master (
    output m_ar_valid, m_ar_addr, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_last, m_r_id
  );

  // Interconnect side: accepts AR, returns R
  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_last, m_r_id
  );
endinterface

// File: rtl/axi_ar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_ar_rr_arbiter
// Round-robin arbiter sharing one AXI AR master port among N_REQ requesters.
// The granted requester index is prefixed onto ARID; R beats are routed back
// by that prefix. Per-requester outstanding-burst counters block a requester
// at MAX_OUTST without stalling the others. A sticky err flags R beats with
// an out-of-range index and last beats arriving with no burst outstanding.
//
// Optional build macro: AXI_ARB_LOG_EN -- when defined, simulation-only
// messages report every AR handshake and the rising edge of err. When not
// defined no simulation code is compiled; ports and timing are identical.
// ---------------------------------------------------------------------------
module axi_ar_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*ID_W-1:0]   req_id,
  axi_ar_rr_arbiter_if.master     m_axi,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_last,
  output logic                    err
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int M_ID_W = ID_W + IDX_W;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W:0]   N_REQ_X  = (IDX_W + 1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Registered state
  state_t            state_r;
  logic              m_ar_valid_r;
  logic [ADDR_W-1:0] m_ar_addr_r;
  logic [M_ID_W-1:0] m_ar_id_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  grant_r;
  logic [CNT_W-1:0]  cnt_r [N_REQ];
  logic              err_r;

  // Combinational decode
  logic [N_REQ-1:0]  elig_s;
  logic              found_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic [IDX_W:0]    sum_s;
  logic [IDX_W-1:0]  cand_s;
  logic              accept_s;
  logic [N_REQ-1:0]  req_ready_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [ID_W-1:0]   sel_id_s;
  logic [IDX_W-1:0]  rr_ptr_next_s;

  logic [IDX_W-1:0]  r_idx_s;
  logic              idx_ok_s;
  logic [N_REQ-1:0]  r_sel_s;
  logic [N_REQ-1:0]  rsp_valid_s;
  logic              m_r_ready_s;
  logic              r_fire_s;
  logic              last_fire_s;
  logic              bad_beat_s;
  logic [N_REQ-1:0]  dec_s;
  logic              underflow_s;
  logic              err_set_s;

  // Requesters allowed to compete: valid and not at their outstanding limit
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_valid[i] && (cnt_r[i] != CNT_MAX);
    end
  end

  // Round-robin scan from rr_ptr_r; walking k downward lets the closest hit win
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_s       = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      cand_s      = IDX_W'((sum_s >= N_REQ_X) ? (sum_s - N_REQ_X) : sum_s);
      grant_idx_s = elig_s[cand_s] ? cand_s : grant_idx_s;
      found_s     = found_s | elig_s[cand_s];
    end
  end

  // Accept decode and one-hot ready; nothing is accepted while reset is held
  always_comb begin
    accept_s    = rst_n && (state_r == ST_IDLE) && found_s;
    req_ready_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_s[i] = accept_s && (grant_idx_s == IDX_W'(i));
    end
  end

  // Address/ID mux of the winning requester (AND-OR select)
  always_comb begin
    sel_addr_s = '0;
    sel_id_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr_s = sel_addr_s |
                   (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_idx_s == IDX_W'(i)}});
      sel_id_s   = sel_id_s |
                   (req_id[i*ID_W +: ID_W] & {ID_W{grant_idx_s == IDX_W'(i)}});
    end
  end

  // Pointer moves past the requester whose AR just completed
  always_comb begin
    rr_ptr_next_s = (grant_r == LAST_IDX) ? '0 : (grant_r + 1'b1);
  end

  // AR grant FSM with registered master outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      m_ar_valid_r <= 1'b0;
      m_ar_addr_r  <= '0;
      m_ar_id_r    <= '0;
      rr_ptr_r     <= '0;
      grant_r      <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r      <= ST_HOLD;
            m_ar_valid_r <= 1'b1;
            m_ar_addr_r  <= sel_addr_s;
            m_ar_id_r    <= {grant_idx_s, sel_id_s};
            grant_r      <= grant_idx_s;
          end else begin
            state_r      <= ST_IDLE;
            m_ar_valid_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (m_axi.m_ar_ready) begin
            state_r      <= ST_IDLE;
            m_ar_valid_r <= 1'b0;
            rr_ptr_r     <= rr_ptr_next_s;
          end else begin
            state_r      <= ST_HOLD;
            m_ar_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          m_ar_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // R routing by the ID prefix; out-of-range prefixes are swallowed
  always_comb begin
    r_idx_s  = m_axi.m_r_id[ID_W +: IDX_W];
    idx_ok_s = ({1'b0, r_idx_s} < N_REQ_X);
    for (int i = 0; i < N_REQ; i++) begin
      r_sel_s[i] = idx_ok_s && (r_idx_s == IDX_W'(i));
    end
    rsp_valid_s = r_sel_s & {N_REQ{m_axi.m_r_valid}};
    m_r_ready_s = idx_ok_s ? (|(rsp_ready & r_sel_s)) : 1'b1;
    r_fire_s    = m_axi.m_r_valid && m_r_ready_s;
    last_fire_s = r_fire_s && m_axi.m_r_last && idx_ok_s;
    bad_beat_s  = r_fire_s && !idx_ok_s;
  end

  // Completion decode; a last beat with nothing outstanding is an underflow
  always_comb begin
    underflow_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      dec_s[i]    = last_fire_s && r_sel_s[i];
      underflow_s = underflow_s |
                    (dec_s[i] && !req_ready_s[i] && (cnt_r[i] == CNT_ZERO));
    end
    err_set_s = bad_beat_s || underflow_s;
  end

  // Outstanding-burst counters; accept and completion in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({req_ready_s[i], dec_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01:   cnt_r[i] <= (cnt_r[i] == CNT_ZERO) ? CNT_ZERO : (cnt_r[i] - CNT_ONE);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

`ifdef AXI_ARB_LOG_EN
  // Simulation trace of AR handshakes and of the first error
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == ST_HOLD) && m_axi.m_ar_ready) begin
      $display("%0t ARB grant req=%0d id=%0h addr=%0h", $time, grant_r, m_ar_id_r, m_ar_addr_r);
    end else begin
    end
    if (rst_n && !err_r && err_set_s) begin
      $display("%0t ARB err idx=%0d", $time, r_idx_s);
    end else begin
    end
  end
`else
  // Trace disabled: no additional logic
`endif

  assign req_ready        = req_ready_s;
  assign m_axi.m_ar_valid = m_ar_valid_r;
  assign m_axi.m_ar_addr  = m_ar_addr_r;
  assign m_axi.m_ar_id    = m_ar_id_r;
  assign m_axi.m_r_ready  = m_r_ready_s;
  assign rsp_valid        = rsp_valid_s;
  assign rsp_id           = m_axi.m_r_id[ID_W-1:0];
  assign rsp_last         = m_axi.m_r_last;
  assign err              = err_r;

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_rr_arbiter
// Directed bench for the round-robin AR arbiter. A cycle-level model of the
// arbiter's rules (grant order, outstanding counts, R routing, sticky error)
// is checked against the 4-requester DUT on every falling edge; directed
// sequences add hand-computed literal checks. A second 3-requester instance
// covers the out-of-range R index.
// ---------------------------------------------------------------------------
module tb_axi_ar_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int MO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*IW-1:0] req_id;
  logic [IW-1:0]   rsp_id;
  logic            rsp_last, err;

  axi_ar_rr_arbiter_if #(.ADDR_W(AW), .M_ID_W(IW + 2)) mif ();

  axi_ar_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_id(req_id),
    .m_axi(mif),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .err(err)
  );

  // Three-requester instance for the out-of-range index case
  logic [2:0]    r3_req_valid, r3_req_ready, r3_rsp_valid, r3_rsp_ready;
  logic [3*AW-1:0] r3_req_addr;
  logic [3*IW-1:0] r3_req_id;
  logic [IW-1:0] r3_rsp_id;
  logic          r3_rsp_last, r3_err;

  axi_ar_rr_arbiter_if #(.ADDR_W(AW), .M_ID_W(IW + 2)) mif3 ();

  axi_ar_rr_arbiter #(.N_REQ(3), .ADDR_W(AW), .ID_W(IW), .MAX_OUTST(MO)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready),
    .req_addr(r3_req_addr), .req_id(r3_req_id),
    .m_axi(mif3),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
    .rsp_id(r3_rsp_id), .rsp_last(r3_rsp_last), .err(r3_err)
  );

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int glog_idx[$];
  int glog_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural model + per-cycle compare ----------------
  bit              mbusy, merr;
  int              mptr, mg, eg, ridx;
  int              mcnt[N];
  logic [AW-1:0]   maddr;
  logic [IW+1:0]   mid;
  logic [N-1:0]    exp_ready, exp_rsp_valid;
  bit              rfire;

  always @(negedge clk) begin
    if (!rst_n) begin
      mbusy = 1'b0; merr = 1'b0; mptr = 0; mg = 0;
      maddr = '0; mid = '0;
      foreach (mcnt[i]) mcnt[i] = 0;
      check("rst_req_ready", req_ready, 64'd0);
      check("rst_ar_valid", mif.m_ar_valid, 64'd0);
      check("rst_ar_addr", mif.m_ar_addr, 64'd0);
      check("rst_ar_id", mif.m_ar_id, 64'd0);
      check("rst_err", err, 64'd0);
    end else begin
      // which requester the rules say is accepted this cycle
      eg = -1;
      if (!mbusy) begin
        for (int k = 0; k < N; k++) begin
          if (eg < 0 && req_valid[(mptr + k) % N] && mcnt[(mptr + k) % N] < MO)
            eg = (mptr + k) % N;
        end
      end
      exp_ready = '0;
      if (eg >= 0) exp_ready[eg] = 1'b1;
      ridx = int'(mif.m_r_id[IW +: 2]);
      exp_rsp_valid = '0;
      if (mif.m_r_valid) exp_rsp_valid[ridx] = 1'b1;

      check("req_ready", req_ready, exp_ready);
      check("ar_valid", mif.m_ar_valid, mbusy);
      check("ar_addr", mif.m_ar_addr, maddr);
      check("ar_id", mif.m_ar_id, mid);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      check("m_r_ready", mif.m_r_ready, rsp_ready[ridx]);
      check("rsp_id", rsp_id, mif.m_r_id[IW-1:0]);
      check("rsp_last", rsp_last, mif.m_r_last);
      check("err", err, merr);

      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            glog_idx.push_back(i);
            glog_cyc.push_back(cyc);
          end
        end
      end

      // state advance for the coming rising edge
      rfire = mif.m_r_valid && rsp_ready[ridx];
      if (rfire && mif.m_r_last && eg != ridx) begin
        if (mcnt[ridx] == 0) merr = 1'b1;
        else mcnt[ridx] = mcnt[ridx] - 1;
      end
      if (eg >= 0) begin
        if (!(rfire && mif.m_r_last && eg == ridx)) mcnt[eg] = mcnt[eg] + 1;
        mbusy = 1'b1;
        mg    = eg;
        maddr = req_addr[eg*AW +: AW];
        mid   = {2'(eg), req_id[eg*IW +: IW]};
      end else if (mbusy && mif.m_ar_ready) begin
        mbusy = 1'b0;
        mptr  = (mg + 1) % N;
      end
    end
  end

  task automatic idle_inputs();
    req_valid = '0;
    rsp_ready = '1;
    mif.m_ar_ready = 1'b1;
    mif.m_r_valid = 1'b0;
    mif.m_r_last = 1'b0;
    mif.m_r_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    glog_idx.delete();
    glog_cyc.delete();
  endtask

  int v;

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 64'h1000_0000 + 64'(i) * 64'h100;
      req_id[i*IW +: IW]   = 4'(i + 8);
    end
    r3_req_valid = '0; r3_req_addr = '0; r3_req_id = '0; r3_rsp_ready = '1;
    mif3.m_ar_ready = 1'b1; mif3.m_r_valid = 1'b0; mif3.m_r_last = 1'b0; mif3.m_r_id = '0;

    // --- single requester 0 ---
    do_reset();
    req_addr[0 +: AW] = 64'h1000;
    req_id[0 +: IW]   = 4'd3;
    req_valid = 4'b0001;
    #1 check("t1_ready_c0", req_ready, 64'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t1_arvalid_c1", mif.m_ar_valid, 64'h1);
    check("t1_arid", mif.m_ar_id, 64'h03);
    check("t1_araddr", mif.m_ar_addr, 64'h1000);
    tick();
    check("t1_arvalid_c2", mif.m_ar_valid, 64'h0);

    // --- all four continuously valid ---
    do_reset();
    req_valid = 4'b1111;
    repeat (10) tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("t2_ngrants", glog_idx.size(), 64'd5);
    for (int k = 0; k < 5; k++) begin
      v = (k < glog_idx.size()) ? glog_idx[k] : -1;
      check("t2_order", v, (k == 4) ? 64'd0 : 64'(k));
    end
    for (int k = 0; k < 4; k++) begin
      v = (k + 1 < glog_cyc.size()) ? glog_cyc[k+1] - glog_cyc[k] : -1;
      check("t2_spacing", v, 64'd2);
    end

    // --- requester 1 fills its outstanding budget ---
    do_reset();
    req_valid = 4'b0010;
    repeat (16) tick();
    req_valid = 4'b0110;
    repeat (6) tick();
    check("t3_ngrants", glog_idx.size(), 64'd11);
    for (int k = 0; k < 11; k++) begin
      v = (k < glog_idx.size()) ? glog_idx[k] : -1;
      check("t3_order", v, (k < 8) ? 64'd1 : 64'd2);
    end
    req_valid = 4'b0000;
    tick();
    tick();
    mif.m_r_valid = 1'b1; mif.m_r_last = 1'b1; mif.m_r_id = 6'h10;
    tick();
    mif.m_r_valid = 1'b0; mif.m_r_last = 1'b0;
    glog_idx.delete();
    req_valid = 4'b0110;
    #1 check("t3_req1_next", req_ready, 64'h2);
    tick();
    req_valid = 4'b0000;
    tick();

    // --- AR back-pressure ---
    do_reset();
    req_addr[2*AW +: AW] = 64'hABC0;
    req_id[2*IW +: IW]   = 4'd7;
    mif.m_ar_ready = 1'b0;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_arvalid", mif.m_ar_valid, 64'h1);
      check("t4_araddr", mif.m_ar_addr, 64'hABC0);
      check("t4_arid", mif.m_ar_id, 64'h27);
      check("t4_noready", req_ready, 64'h0);
      tick();
    end
    mif.m_ar_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    tick();

    // --- R routing with requester back-pressure ---
    mif.m_r_valid = 1'b1; mif.m_r_last = 1'b1; mif.m_r_id = 6'h25;
    rsp_ready = 4'b1011;
    #1;
    check("t5_mrready_stall", mif.m_r_ready, 64'h0);
    check("t5_rspvalid", rsp_valid, 64'h4);
    check("t5_rspid", rsp_id, 64'h5);
    check("t5_rsplast", rsp_last, 64'h1);
    tick();
    tick();
    check("t5_err_stall", err, 64'h0);
    rsp_ready = 4'b1111;
    #1 check("t5_mrready_go", mif.m_r_ready, 64'h1);
    tick();
    mif.m_r_valid = 1'b0;
    #1 check("t5_err_after_dec", err, 64'h0);
    mif.m_r_valid = 1'b1;
    tick();
    mif.m_r_valid = 1'b0; mif.m_r_last = 1'b0;
    #1 check("t5_err_underflow", err, 64'h1);
    tick();
    check("t5_err_sticky", err, 64'h1);

    // --- reset while holding an AR ---
    mif.m_ar_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    #1;
    check("t6_arvalid_hold", mif.m_ar_valid, 64'h1);
    check("t6_err_before", err, 64'h1);
    rst_n = 1'b0;
    #1;
    check("t6_arvalid_async", mif.m_ar_valid, 64'h0);
    check("t6_err_async", err, 64'h0);
    check("t6_arid_async", mif.m_ar_id, 64'h0);
    tick();
    rst_n = 1'b1;
    mif.m_ar_ready = 1'b1;
    tick();
    check("t6_no_replay_a", mif.m_ar_valid, 64'h0);
    tick();
    check("t6_no_replay_b", mif.m_ar_valid, 64'h0);

    // --- three requesters: index 3 is out of range ---
    check("t7_err_init", r3_err, 64'h0);
    mif3.m_r_valid = 1'b1; mif3.m_r_last = 1'b1; mif3.m_r_id = 6'h31;
    #1;
    check("t7_mrready", mif3.m_r_ready, 64'h1);
    check("t7_rspvalid", r3_rsp_valid, 64'h0);
    tick();
    mif3.m_r_valid = 1'b0; mif3.m_r_last = 1'b0;
    #1 check("t7_err_set", r3_err, 64'h1);
    tick();
    tick();
    check("t7_err_sticky", r3_err, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
